// File: rtl/elastic_pipe_pkg.sv
// elastic_pipe_pkg: shared constants for the elastic pipeline
package elastic_pipe_pkg;
  localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/elastic_pipe_stage.sv
// pipe_stage: one data register plus valid bit with load and clear
module pipe_stage
  import elastic_pipe_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             res,
  input  logic             load,
  input  logic             clr,
  input  logic [WIDTH-1:0] d_in,
  output logic             valid,
  output logic [WIDTH-1:0] data
);
  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d, data_q;
  // an incoming item wins over the clear of the departing one
  always_comb begin
    valid_d = load | (valid_q & ~clr);
    data_d  = load ? d_in : data_q;
  end
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign valid = valid_q;
  assign data  = data_q;
endmodule

// File: rtl/elastic_pipe.sv
// elastic_pipe: DEPTH-stage valid/ready pipeline with bubble collapse, enable and flush
module elastic_pipe
  import elastic_pipe_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       res,
  input  logic                       en,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           d,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           q,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [DEPTH-1:0] valid, move, load, clr;
  logic [WIDTH-1:0] data [DEPTH];
  logic             accept;
  logic [CW-1:0]    count_d, count_q;
  // move resolves from the output end backwards so bubbles collapse
  always_comb begin
    move = '0;
    move[DEPTH-1] = valid[DEPTH-1] & out_ready & en;
    for (int k = DEPTH - 2; k >= 0; k--)
      move[k] = valid[k] & en & (~valid[k+1] | move[k+1]);
  end
  // held low during reset so nothing is accepted until res is released
  assign in_ready = res & en & ~flush & (~valid[0] | move[0]);
  assign accept   = in_valid & in_ready;
  always_comb begin
    load    = '0;
    load[0] = accept;
    for (int k = 1; k < DEPTH; k++)
      load[k] = move[k-1] & ~flush;
    clr = {DEPTH{flush}} | move;
  end
  for (genvar i = 0; i < DEPTH; i++) begin : g_st
    logic [WIDTH-1:0] d_in;
    if (i == 0) begin : g_in
      assign d_in = d;
    end else begin : g_mid
      assign d_in = data[i-1];
    end
    pipe_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
      .clk  (clk),
      .res  (res),
      .load (load[i]),
      .clr  (clr[i]),
      .d_in (d_in),
      .valid(valid[i]),
      .data (data[i])
    );
  end
  always_comb count_d = flush ? '0 : count_q + CW'(accept) - CW'(move[DEPTH-1] & ~flush);
  always_ff @(posedge clk or negedge res) begin
    if (!res) count_q <= '0;
    else      count_q <= count_d;
  end
  assign count     = count_q;
  assign out_valid = valid[DEPTH-1];
  assign q         = data[DEPTH-1];
endmodule
